trap_controller: RTL and testbench

Sequencer for the machine-mode trap path. It takes exception and interrupt requests from the pipeline, arbitrates them by fixed RISC-V priority, and drains the pipeline. It then drives the one-hot `trapTrigger` / `trapReturn` pulses into the core status block (privilege mode + mstatus) along with the mcause/mepc/mtval writes and the PC redirect. It sits between the pipeline's hazard/flush logic and the CSR file.

---
 rtl/trap_pkg.sv | 56 +++++
 rtl/trap_priority_encoder.sv | 24 ++
 rtl/trap_controller.sv | 157 +++++++++++++++
 tb/tb_trap_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer:
// FSM states, cause codes, fixed priority orders and mtvec modes.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_TRAP_FLUSH  = 3'd1,
    ST_TRAP_COMMIT = 3'd2,
    ST_RET_FLUSH   = 3'd3,
    ST_RET_COMMIT  = 3'd4
  } trap_state_t;

  // Synchronous exception cause codes
  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] EXC_INSTR_FAULT      = 4'd1;
  localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;
  localparam logic [3:0] EXC_ECALL_U          = 4'd8;
  localparam logic [3:0] EXC_ECALL_S          = 4'd9;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;
  localparam logic [3:0] EXC_INSTR_PAGE_FAULT = 4'd12;
  localparam logic [3:0] EXC_LOAD_PAGE_FAULT  = 4'd13;
  localparam logic [3:0] EXC_STORE_PAGE_FAULT = 4'd15;

  // Interrupt cause codes
  localparam logic [3:0] IRQ_SSI = 4'd1;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_STI = 4'd5;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_SEI = 4'd9;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // Priority lists: element [0] is the highest priority, unused tail entries are padding
  localparam int EXC_PRIO_NUM = 14;
  localparam logic [15:0][3:0] EXC_PRIO = {
    4'd0, 4'd0,
    EXC_LOAD_FAULT, EXC_STORE_FAULT, EXC_LOAD_PAGE_FAULT, EXC_STORE_PAGE_FAULT,
    EXC_LOAD_MISALIGNED, EXC_STORE_MISALIGNED, EXC_ECALL_M, EXC_ECALL_S,
    EXC_ECALL_U, EXC_INSTR_MISALIGNED, EXC_ILLEGAL_INSTR, EXC_INSTR_FAULT,
    EXC_INSTR_PAGE_FAULT, EXC_BREAKPOINT
  };

  localparam int IRQ_PRIO_NUM = 6;
  localparam logic [15:0][3:0] IRQ_PRIO = {
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
    IRQ_STI, IRQ_SSI, IRQ_SEI, IRQ_MTI, IRQ_MSI, IRQ_MEI
  };

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_priority_encoder.sv
// Fixed-priority encoder: returns the highest-ranked set request bit from a
// parameterised ordered list of cause codes. Bits not in the list are ignored.
module trap_priority_encoder #(
  parameter int               NUM  = 16,
  parameter logic [15:0][3:0] PRIO = '0
) (
  input  logic [15:0] req_i,
  output logic [3:0]  code_o,
  output logic        valid_o
);

  always_comb begin
    code_o  = '0;
    valid_o = 1'b0;
    // Walk lowest to highest so the highest-priority hit is written last
    for (int i = NUM - 1; i >= 0; i--) begin
      if (req_i[PRIO[i]]) begin
        code_o  = PRIO[i];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates exceptions/interrupts/MRET, drains
// the pipeline, then emits one-cycle commit pulses, CSR writes and redirect.
module trap_controller
  import trap_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  excReq,
  input  logic [N-1:0] excPc,
  input  logic [N-1:0] excTval,
  input  logic [15:0]  mip,
  input  logic [15:0]  mie,
  input  logic         mstatusMie,
  input  logic [1:0]   currentMode,
  input  logic         mretReq,
  input  logic [N-1:0] mtvec,
  input  logic [N-1:0] mepcIn,
  input  logic         pipeEmpty,
  output logic         flush,
  output logic [15:0]  trapTrigger,
  output logic         trapIsInterrupt,
  output logic         trapReturn,
  output logic         csrWe,
  output logic [N-1:0] mcauseOut,
  output logic [N-1:0] mepcOut,
  output logic [N-1:0] mtvalOut,
  output logic         redirect,
  output logic [N-1:0] redirectPc
);

  trap_state_t  state_q, state_d;
  logic [3:0]   cause_q, cause_d;
  logic         is_int_q, is_int_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] tval_q, tval_d;

  logic [3:0]   exc_code, irq_code;
  logic         exc_valid, irq_valid;
  logic         irq_take;
  logic [N-1:0] tvec_base;

  trap_priority_encoder #(
    .NUM  (EXC_PRIO_NUM),
    .PRIO (EXC_PRIO)
  ) u_exc_enc (
    .req_i   (excReq),
    .code_o  (exc_code),
    .valid_o (exc_valid)
  );

  trap_priority_encoder #(
    .NUM  (IRQ_PRIO_NUM),
    .PRIO (IRQ_PRIO)
  ) u_irq_enc (
    .req_i   (mip & mie),
    .code_o  (irq_code),
    .valid_o (irq_valid)
  );

  // Below M-mode interrupts are always globally enabled; in M-mode mstatus.MIE gates them
  assign irq_take  = irq_valid && ((currentMode != 2'b11) || mstatusMie);
  assign tvec_base = {mtvec[N-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cause_q  <= '0;
      is_int_q <= 1'b0;
      pc_q     <= '0;
      tval_q   <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      is_int_q <= is_int_d;
      pc_q     <= pc_d;
      tval_q   <= tval_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cause_d         = cause_q;
    is_int_d        = is_int_q;
    pc_d            = pc_q;
    tval_d          = tval_q;
    flush           = 1'b0;
    trapTrigger     = '0;
    trapIsInterrupt = 1'b0;
    trapReturn      = 1'b0;
    csrWe           = 1'b0;
    mcauseOut       = '0;
    mepcOut         = '0;
    mtvalOut        = '0;
    redirect        = 1'b0;
    redirectPc      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          cause_d  = exc_code;
          is_int_d = 1'b0;
          pc_d     = excPc;
          tval_d   = excTval;
          state_d  = ST_TRAP_FLUSH;
        end else if (irq_take) begin
          cause_d  = irq_code;
          is_int_d = 1'b1;
          pc_d     = excPc;
          tval_d   = '0;
          state_d  = ST_TRAP_FLUSH;
        end else if (mretReq) begin
          state_d  = ST_RET_FLUSH;
        end
      end

      ST_TRAP_FLUSH: begin
        flush = 1'b1;
        if (pipeEmpty) state_d = ST_TRAP_COMMIT;
      end

      ST_TRAP_COMMIT: begin
        flush           = 1'b1;
        trapTrigger     = 16'd1 << cause_q;
        trapIsInterrupt = is_int_q;
        csrWe           = 1'b1;
        mcauseOut       = {is_int_q, {(N-5){1'b0}}, cause_q};
        mepcOut         = {pc_q[N-1:2], 2'b00};
        mtvalOut        = tval_q;
        redirect        = 1'b1;
        // Only vectored mode offsets interrupts; reserved modes behave as direct
        if ((mtvec[1:0] == MTVEC_VECTORED) && is_int_q)
          redirectPc = tvec_base + {{(N-6){1'b0}}, cause_q, 2'b00};
        else
          redirectPc = tvec_base;
        state_d = ST_IDLE;
      end

      ST_RET_FLUSH: begin
        flush = 1'b1;
        if (pipeEmpty) state_d = ST_RET_COMMIT;
      end

      ST_RET_COMMIT: begin
        flush      = 1'b1;
        trapReturn = 1'b1;
        redirect   = 1'b1;
        redirectPc = {mepcIn[N-1:2], 2'b00};
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: hand-computed expectations for reset,
// exception/interrupt arbitration, vectoring, drain latency, MRET and reset abort.
module tb_trap_controller;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  excReq;
  logic [N-1:0] excPc;
  logic [N-1:0] excTval;
  logic [15:0]  mip;
  logic [15:0]  mie;
  logic         mstatusMie;
  logic [1:0]   currentMode;
  logic         mretReq;
  logic [N-1:0] mtvec;
  logic [N-1:0] mepcIn;
  logic         pipeEmpty;
  logic         flush;
  logic [15:0]  trapTrigger;
  logic         trapIsInterrupt;
  logic         trapReturn;
  logic         csrWe;
  logic [N-1:0] mcauseOut;
  logic [N-1:0] mepcOut;
  logic [N-1:0] mtvalOut;
  logic         redirect;
  logic [N-1:0] redirectPc;

  int checks   = 0;
  int failures = 0;
  int flush_cnt;

  trap_controller #(.N(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .excReq          (excReq),
    .excPc           (excPc),
    .excTval         (excTval),
    .mip             (mip),
    .mie             (mie),
    .mstatusMie      (mstatusMie),
    .currentMode     (currentMode),
    .mretReq         (mretReq),
    .mtvec           (mtvec),
    .mepcIn          (mepcIn),
    .pipeEmpty       (pipeEmpty),
    .flush           (flush),
    .trapTrigger     (trapTrigger),
    .trapIsInterrupt (trapIsInterrupt),
    .trapReturn      (trapReturn),
    .csrWe           (csrWe),
    .mcauseOut       (mcauseOut),
    .mepcOut         (mepcOut),
    .mtvalOut        (mtvalOut),
    .redirect        (redirect),
    .redirectPc      (redirectPc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 2ns after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet_inputs();
    excReq      = '0;
    excPc       = '0;
    excTval     = '0;
    mip         = '0;
    mie         = '0;
    mstatusMie  = 1'b0;
    currentMode = 2'b11;
    mretReq     = 1'b0;
    mtvec       = 64'h8000_0000;
    mepcIn      = '0;
    pipeEmpty   = 1'b1;
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_flush"},   {63'd0, flush},      64'd0);
    check({tag, "_trig"},    {48'd0, trapTrigger}, 64'd0);
    check({tag, "_ret"},     {63'd0, trapReturn}, 64'd0);
    check({tag, "_we"},      {63'd0, csrWe},      64'd0);
    check({tag, "_redir"},   {63'd0, redirect},   64'd0);
    check({tag, "_rpc"},     redirectPc,          64'd0);
    check({tag, "_mcause"},  mcauseOut,           64'd0);
    check({tag, "_mepc"},    mepcOut,             64'd0);
  endtask

  initial begin
    quiet_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_all_quiet("reset");
    reset = 1'b0;
    tick();
    check_all_quiet("post_reset");

    // Illegal instruction, pipeline already empty
    excReq  = 16'h0004;
    excPc   = 64'h8000_0104;
    excTval = 64'h0000_0000_DEAD_BEEF;
    tick();
    excReq  = '0;
    check("ill_k1_flush", {63'd0, flush}, 64'd1);
    check("ill_k1_trig", {48'd0, trapTrigger}, 64'd0);
    tick();
    check("ill_trig",   {48'd0, trapTrigger}, 64'h0004);
    check("ill_isint",  {63'd0, trapIsInterrupt}, 64'd0);
    check("ill_we",     {63'd0, csrWe}, 64'd1);
    check("ill_mcause", mcauseOut, 64'd2);
    check("ill_mepc",   mepcOut, 64'h8000_0104);
    check("ill_mtval",  mtvalOut, 64'h0000_0000_DEAD_BEEF);
    check("ill_redir",  {63'd0, redirect}, 64'd1);
    check("ill_rpc",    redirectPc, 64'h8000_0000);
    check("ill_flush",  {63'd0, flush}, 64'd1);
    tick();
    check("ill_done_flush", {63'd0, flush}, 64'd0);
    check("ill_done_trig", {48'd0, trapTrigger}, 64'd0);

    // ecall-M + breakpoint with an enabled MTI under vectored mtvec: breakpoint wins
    mtvec      = 64'h8000_0001;
    excReq     = 16'h0808;
    excPc      = 64'h8000_0200;
    mip        = 16'h0080;
    mie        = 16'h0080;
    mstatusMie = 1'b1;
    tick();
    excReq = '0;
    mip    = '0;
    tick();
    check("prio_trig",   {48'd0, trapTrigger}, 64'h0008);
    check("prio_isint",  {63'd0, trapIsInterrupt}, 64'd0);
    check("prio_mcause", mcauseOut, 64'd3);
    check("prio_rpc",    redirectPc, 64'h8000_0000);
    tick();

    // Vectored machine timer interrupt; tval forced to zero
    excPc   = 64'h8000_0402;
    excTval = 64'h1234;
    mip     = 16'h0080;
    tick();
    mip = '0;
    tick();
    check("mti_trig",   {48'd0, trapTrigger}, 64'h0080);
    check("mti_isint",  {63'd0, trapIsInterrupt}, 64'd1);
    check("mti_mcause", mcauseOut, 64'h8000_0000_0000_0007);
    check("mti_rpc",    redirectPc, 64'h8000_001C);
    check("mti_mtval",  mtvalOut, 64'd0);
    check("mti_mepc",   mepcOut, 64'h8000_0400);
    tick();

    // M-mode with MIE clear: pending MTI must not trap
    mstatusMie = 1'b0;
    mip        = 16'h0080;
    tick();
    check("mie0_flush_a", {63'd0, flush}, 64'd0);
    tick();
    check("mie0_flush_b", {63'd0, flush}, 64'd0);
    check("mie0_trig", {48'd0, trapTrigger}, 64'd0);

    // Same pending MTI from U-mode is taken regardless of MIE
    currentMode = 2'b00;
    tick();
    mip = '0;
    check("umode_flush", {63'd0, flush}, 64'd1);
    tick();
    check("umode_trig", {48'd0, trapTrigger}, 64'h0080);
    tick();
    currentMode = 2'b11;
    mie         = '0;
    mtvec       = 64'h8000_0000;

    // Drain: load-misaligned, pipeEmpty low for 3 cycles, excReq changes mid-flush
    excReq    = 16'h0010;
    excPc     = 64'h8000_0010;
    excTval   = 64'h55;
    pipeEmpty = 1'b0;
    flush_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (flush) flush_cnt++;
      if (c == 5) begin
        check("drain_trig",   {48'd0, trapTrigger}, 64'h0010);
        check("drain_mcause", mcauseOut, 64'd4);
        check("drain_mtval",  mtvalOut, 64'h55);
      end else begin
        check($sformatf("drain_c%0d_trig", c), {48'd0, trapTrigger}, 64'd0);
      end
      if (c == 1) excReq = 16'h0008;
      if (c == 4) begin
        pipeEmpty = 1'b1;
        excReq    = '0;
      end
    end
    check("drain_flush_cycles", flush_cnt, 64'd5);

    // MRET
    mretReq = 1'b1;
    mepcIn  = 64'h8000_0203;
    tick();
    mretReq = 1'b0;
    check("mret_k1_flush", {63'd0, flush}, 64'd1);
    check("mret_k1_ret", {63'd0, trapReturn}, 64'd0);
    tick();
    check("mret_ret",   {63'd0, trapReturn}, 64'd1);
    check("mret_redir", {63'd0, redirect}, 64'd1);
    check("mret_rpc",   redirectPc, 64'h8000_0200);
    check("mret_we",    {63'd0, csrWe}, 64'd0);
    check("mret_trig",  {48'd0, trapTrigger}, 64'd0);
    tick();
    check("mret_after_ret", {63'd0, trapReturn}, 64'd0);

    // MRET together with an exception: trap wins, no return pulse
    mretReq = 1'b1;
    excReq  = 16'h0001;
    excPc   = 64'h8000_0300;
    tick();
    mretReq = 1'b0;
    excReq  = '0;
    tick();
    check("mretx_trig",   {48'd0, trapTrigger}, 64'h0001);
    check("mretx_ret",    {63'd0, trapReturn}, 64'd0);
    check("mretx_mcause", mcauseOut, 64'd0);
    tick();
    check("mretx_after_ret", {63'd0, trapReturn}, 64'd0);

    // Reset during TRAP_FLUSH kills the pending trap
    excReq    = 16'h0004;
    pipeEmpty = 1'b0;
    tick();
    excReq = '0;
    check("rst_pre_flush", {63'd0, flush}, 64'd1);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    pipeEmpty = 1'b1;
    check_all_quiet("rst_abort");
    tick();
    check("rst_no_pulse_a", {48'd0, trapTrigger}, 64'd0);
    tick();
    check("rst_no_pulse_b", {48'd0, trapTrigger}, 64'd0);
    check("rst_idle_flush", {63'd0, flush}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
